// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output buffer for one router channel.
// Each entry carries a header tag bit above the data word. The block tracks
// how many bytes of the current packet are still unread and how many
// headers are held, and it latches overflow/underflow errors until reset.
module router_pkt_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int ADD_WIDTH = 4,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int LFD_DELAY = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 soft_reset,
   input  logic                 write_enb,
   input  logic                 read_enb,
   input  logic                 lfd_state,
   input  logic [WIDTH-1:0]     data_in,
   output logic [WIDTH-1:0]     data_out,
   output logic                 data_valid,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADD_WIDTH:0]   occupancy,
   output logic [ADD_WIDTH:0]   pkt_count,
   output logic [WIDTH-2:0]     pkt_remaining,
   output logic                 overflow_err,
   output logic                 underflow_err
);

   localparam int PW = ADD_WIDTH + 1;
   localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [WIDTH-2:0] REM_ONE = (WIDTH-1)'(1);

   // Bit WIDTH of each entry is the header tag.
   logic [WIDTH:0]   mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             lfd_q;
   logic             flush;
   logic             wr_acc;
   logic             rd_acc;
   logic             tag_in;
   logic             tag_wr;
   logic             tag_rd;
   logic [WIDTH:0]   rd_word;

   // Status flags derive directly from the pointers so they reflect the
   // state before the next edge; acceptance decisions use these values.
   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                         (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign occupancy    = wr_ptr - rd_ptr;
   assign almost_full  = (occupancy >= AF_T);
   assign almost_empty = (occupancy <= AE_T);

   // A full FIFO rejects writes even when a read frees a slot on the same
   // edge; an empty FIFO rejects reads even when a write lands on that edge.
   assign flush   = reset || soft_reset;
   assign wr_acc  = write_enb && !full;
   assign rd_acc  = read_enb && !empty;
   assign tag_in  = (LFD_DELAY != 0) ? lfd_q : lfd_state;
   assign rd_word = mem[rd_ptr[ADD_WIDTH-1:0]];
   assign tag_wr  = wr_acc && tag_in;
   assign tag_rd  = rd_acc && rd_word[WIDTH];

   // Storage is never cleared; the pointer reset alone discards contents.
   always_ff @(posedge clock) begin
      if (!flush && wr_acc)
         mem[wr_ptr[ADD_WIDTH-1:0]] <= {tag_in, data_in};
   end

   // Read and write pointers, wrapping naturally on the extra MSB.
   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Registered read port: data_out holds its last value between reads.
   always_ff @(posedge clock) begin
      if (flush) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= rd_acc;
         if (rd_acc) data_out <= rd_word[WIDTH-1:0];
      end
   end

   // Header count: a tagged write and tagged read on one edge cancel out.
   always_ff @(posedge clock) begin
      if (flush)
         pkt_count <= '0;
      else if (tag_wr && !tag_rd)
         pkt_count <= pkt_count + PTR_ONE;
      else if (!tag_wr && tag_rd)
         pkt_count <= pkt_count - PTR_ONE;
   end

   // Bytes left in the packet being read: a header loads payload length
   // plus one parity byte, every other byte counts down to zero.
   always_ff @(posedge clock) begin
      if (flush)
         pkt_remaining <= '0;
      else if (rd_acc) begin
         if (rd_word[WIDTH])
            pkt_remaining <= {1'b0, rd_word[WIDTH-1:2]} + REM_ONE;
         else if (pkt_remaining != '0)
            pkt_remaining <= pkt_remaining - REM_ONE;
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge clock) begin
      if (flush) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (write_enb && full)  overflow_err  <= 1'b1;
         if (read_enb && empty)  underflow_err <= 1'b1;
      end
   end

   // One-cycle-delayed header marker for write paths where the FSM raises
   // lfd_state ahead of the header byte.
   always_ff @(posedge clock) begin
      if (flush) lfd_q <= 1'b0;
      else       lfd_q <= lfd_state;
   end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed scenarios plus a randomized run, checked
// against a queue-based model of the packet FIFO.
module tb_router_pkt_fifo;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       data_valid, empty, full, almost_full, almost_empty;
   logic [4:0] occupancy, pkt_count;
   logic [6:0] pkt_remaining;
   logic       overflow_err, underflow_err;

   // second instance exercising the delayed header marker
   logic       d_sr = 1'b0, d_we = 1'b0, d_re = 1'b0, d_lfd = 1'b0;
   logic [7:0] d_din = '0;
   logic [7:0] d_dout;
   logic       d_dv, d_empty, d_full, d_af, d_ae, d_ovf, d_udf;
   logic [4:0] d_occ, d_pc;
   logic [6:0] d_rem;

   int errs = 0;
   int checks = 0;

   // model state
   logic [8:0] q[$];
   logic [7:0] m_dout;
   logic       m_dv, m_ovf, m_udf;
   int         m_pc;
   int         m_rem;

   always #5 clock = ~clock;

   router_pkt_fifo dut (
      .clock(clock), .reset(reset), .soft_reset(soft_reset),
      .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
      .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
      .empty(empty), .full(full), .almost_full(almost_full),
      .almost_empty(almost_empty), .occupancy(occupancy),
      .pkt_count(pkt_count), .pkt_remaining(pkt_remaining),
      .overflow_err(overflow_err), .underflow_err(underflow_err));

   router_pkt_fifo #(.LFD_DELAY(1)) u_d (
      .clock(clock), .reset(reset), .soft_reset(d_sr),
      .write_enb(d_we), .read_enb(d_re), .lfd_state(d_lfd),
      .data_in(d_din), .data_out(d_dout), .data_valid(d_dv),
      .empty(d_empty), .full(d_full), .almost_full(d_af),
      .almost_empty(d_ae), .occupancy(d_occ),
      .pkt_count(d_pc), .pkt_remaining(d_rem),
      .overflow_err(d_ovf), .underflow_err(d_udf));

   task automatic model_clear();
      q.delete();
      m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0; m_pc = 0; m_rem = 0;
   endtask

   // Apply one cycle of stimulus and advance the model at the edge.
   task automatic step(input logic we, input logic re, input logic lfd,
                       input logic [7:0] d, input logic sr);
      bit f, e;
      logic [8:0] w;
      write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
      soft_reset = sr;
      @(posedge clock);
      if (sr) model_clear();
      else begin
         f = (q.size() == 16);
         e = (q.size() == 0);
         if (we && f) m_ovf = 1;
         if (re && e) m_udf = 1;
         m_dv = 0;
         if (re && !e) begin
            w = q.pop_front();
            m_dout = w[7:0];
            m_dv = 1;
            if (w[8]) begin
               m_pc--;
               m_rem = int'(w[7:2]) + 1;
            end else if (m_rem > 0) m_rem--;
         end
         if (we && !f) begin
            q.push_back({lfd, d});
            if (lfd) m_pc++;
         end
      end
      #1;
      write_enb = 0; read_enb = 0; lfd_state = 0; soft_reset = 0;
   endtask

   task automatic wr(input logic [7:0] d, input logic lfd);
      step(1, 0, lfd, d, 0);
   endtask

   task automatic rd();
      step(0, 1, 0, 8'h00, 0);
   endtask

   task automatic do_reset();
      reset = 1; write_enb = 1; data_in = 8'hEE;
      repeat (2) @(posedge clock);
      model_clear();
      #1;
      reset = 0; write_enb = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (occupancy !== 5'd0) begin errs++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin errs++; $display("FAIL reset_dout got=%h/%b exp=00/0", data_out, data_valid); end
      checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b%b exp=00", overflow_err, underflow_err); end
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errs++; $display("FAIL reset_almost got=ae%b af%b exp=ae1 af0", almost_empty, almost_full); end
   endtask

   task automatic test_packet();
      logic [7:0] exp_d [5];
      int exp_r [5];
      exp_d = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
      exp_r = '{4, 3, 2, 1, 0};
      do_reset();
      wr(8'h0D, 1);
      for (int i = 1; i < 5; i++) wr(exp_d[i], 0);
      checks++; if (pkt_count !== 5'd1) begin errs++; $display("FAIL pkt_count got=%0d exp=1", pkt_count); end
      checks++; if (occupancy !== 5'd5) begin errs++; $display("FAIL pkt_occ got=%0d exp=5", occupancy); end
      for (int i = 0; i < 5; i++) begin
         rd();
         checks++;
         if (data_out !== exp_d[i] || data_valid !== 1'b1 || int'(pkt_remaining) != exp_r[i])
            begin errs++; $display("FAIL pkt_read%0d got=%h/%b/%0d exp=%h/1/%0d", i, data_out, data_valid, pkt_remaining, exp_d[i], exp_r[i]); end
      end
      checks++; if (pkt_count !== 5'd0) begin errs++; $display("FAIL pkt_count_end got=%0d exp=0", pkt_count); end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         wr(8'(8'h40 + i), 0);
         checks++;
         if (almost_full !== ((i + 1) >= 14)) begin errs++; $display("FAIL af_w%0d got=%b exp=%b", i + 1, almost_full, (i + 1) >= 14); end
      end
      checks++; if (full !== 1'b1) begin errs++; $display("FAIL full got=%b exp=1", full); end
      wr(8'hFF, 0);
      checks++; if (occupancy !== 5'd16 || overflow_err !== 1'b1) begin errs++; $display("FAIL ovf got=occ%0d ovf%b exp=occ16 ovf1", occupancy, overflow_err); end
      rd();
      checks++; if (data_out !== 8'h40) begin errs++; $display("FAIL ovf_first got=%h exp=40", data_out); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 12; i++) wr(8'(i), 0);
      for (int i = 0; i < 12; i++) rd();
      for (int i = 0; i < 16; i++) wr(8'(8'h80 + 3 * i), 0);
      checks++; if (full !== 1'b1) begin errs++; $display("FAIL wrap_full got=%b exp=1", full); end
      for (int i = 0; i < 16; i++) begin
         rd();
         checks++;
         if (data_out !== 8'(8'h80 + 3 * i)) begin errs++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, data_out, 8'(8'h80 + 3 * i)); end
      end
      checks++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_empty got=%b exp=1", empty); end
   endtask

   task automatic test_simul();
      do_reset();
      for (int i = 0; i < 8; i++) wr(8'(i), 0);
      step(1, 1, 0, 8'h99, 0);
      checks++; if (occupancy !== 5'd8) begin errs++; $display("FAIL simul_mid got=%0d exp=8", occupancy); end
      for (int i = 0; i < 8; i++) wr(8'(i), 0);
      step(1, 1, 0, 8'h99, 0);
      checks++; if (occupancy !== 5'd15) begin errs++; $display("FAIL simul_full got=%0d exp=15", occupancy); end
      do_reset();
      step(1, 1, 0, 8'h77, 0);
      checks++; if (occupancy !== 5'd1 || underflow_err !== 1'b1) begin errs++; $display("FAIL simul_empty got=occ%0d udf%b exp=occ1 udf1", occupancy, underflow_err); end
   endtask

   task automatic test_soft_reset();
      do_reset();
      rd();
      wr(8'h0D, 1);
      for (int i = 0; i < 7; i++) wr(8'(8'hB0 + i), 0);
      rd(); rd();
      checks++; if (occupancy !== 5'd6 || pkt_remaining !== 7'd3) begin errs++; $display("FAIL soft_pre got=occ%0d rem%0d exp=occ6 rem3", occupancy, pkt_remaining); end
      step(0, 0, 0, 8'h00, 1);
      checks++;
      if (occupancy !== 5'd0 || pkt_count !== 5'd0 || pkt_remaining !== 7'd0 || underflow_err !== 1'b0 || empty !== 1'b1 || data_out !== 8'h00)
         begin errs++; $display("FAIL soft_clear got=occ%0d pc%0d rem%0d udf%b e%b d%h exp=0/0/0/0/1/00", occupancy, pkt_count, pkt_remaining, underflow_err, empty, data_out); end
      wr(8'h33, 0);
      rd();
      checks++; if (data_out !== 8'h33) begin errs++; $display("FAIL soft_after got=%h exp=33", data_out); end
   endtask

   task automatic test_lfd_delay();
      do_reset();
      d_lfd = 1; @(posedge clock); #1;
      d_lfd = 0; d_we = 1; d_din = 8'h11; @(posedge clock); #1;
      d_din = 8'h22; @(posedge clock); #1;
      d_we = 0;
      checks++; if (d_pc !== 5'd1 || d_occ !== 5'd2) begin errs++; $display("FAIL lfd_pc got=pc%0d occ%0d exp=pc1 occ2", d_pc, d_occ); end
      d_re = 1; @(posedge clock); #1;
      checks++; if (d_dout !== 8'h11 || d_rem !== 7'd5 || d_pc !== 5'd0) begin errs++; $display("FAIL lfd_hdr got=%h rem%0d pc%0d exp=11 rem5 pc0", d_dout, d_rem, d_pc); end
      @(posedge clock); #1;
      d_re = 0;
      checks++; if (d_dout !== 8'h22 || d_rem !== 7'd4) begin errs++; $display("FAIL lfd_body got=%h rem%0d exp=22 rem4", d_dout, d_rem); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
              1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom_range(0, 79) == 0));
         checks++;
         if (int'(occupancy) != q.size() || empty !== (q.size() == 0) || full !== (q.size() == 16) ||
             almost_full !== (q.size() >= 14) || almost_empty !== (q.size() <= 2))
            begin errs++; $display("FAIL rnd_status n=%0d got=occ%0d e%b f%b af%b ae%b exp_occ=%0d", n, occupancy, empty, full, almost_full, almost_empty, q.size()); end
         checks++;
         if (data_valid !== m_dv || data_out !== m_dout || int'(pkt_count) != m_pc || int'(pkt_remaining) != m_rem ||
             overflow_err !== m_ovf || underflow_err !== m_udf)
            begin errs++; $display("FAIL rnd_data n=%0d got=%b/%h/%0d/%0d/%b%b exp=%b/%h/%0d/%0d/%b%b", n, data_valid, data_out, pkt_count, pkt_remaining, overflow_err, underflow_err, m_dv, m_dout, m_pc, m_rem, m_ovf, m_udf); end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_packet();
      test_full_overflow();
      test_wrap();
      test_simul();
      test_soft_reset();
      test_lfd_delay();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
